xpack_stream: RTL
=================

Name: xpack_stream

Overview:
- Downstream consumer of the fixed-latency delay stage.
- Takes the delayed BWID-bit sample stream plus its data-valid strobe and packs N_PACK consecutive samples into one wide word.
- Words are buffered in a small show-ahead FIFO and presented on a valid/ready interface to the next bus or DMA stage.
- The input has no backpressure, so FIFO overflow is detected and flagged, never stalled.

Parameters:
- BWID, 8, sample width in bits.
- N_PACK, 4, samples per output word (>=1).
- DEPTH, 4, FIFO depth in words (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- iv_data  in  BWID  input sample.
- i_nd  in  1  input sample valid.
- i_sof  in  1  start of frame; meaningful only when i_nd=1.
- i_rdy  in  1  downstream ready.
- i_clr_ovf  in  1  clears sticky overflow flag.
- ov_data  out  BWID*N_PACK  packed word; lane 0 in LSBs holds the earliest sample.
- ov_nvld  out  clog2(N_PACK+1)  number of valid lanes in ov_data.
- o_sof  out  1  word holds the first sample of a frame.
- o_dv  out  1  output word valid.
- o_ovf  out  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0 at a clk edge):
  - lane counter = 0, assembly register = 0, FIFO empty.
  - o_dv=0, ov_data=0, ov_nvld=0, o_sof=0, o_ovf=0.
  - Applies mid-operation: the partial word and all FIFO contents are discarded.
- Lane counter cnt runs 0..N_PACK-1. On each i_nd=1, iv_data is written to lane cnt and cnt increments.
- Word completes when i_nd=1 and cnt=N_PACK-1 (and i_sof=0). On that same edge:
  - push {iv_data, lanes N_PACK-2..0} with nvld=N_PACK;
  - cnt returns to 0 and the assembly register is cleared.
- Frame start, i_nd=1 and i_sof=1:
  - If cnt>0, first push the partial word: unused lanes zero, nvld=cnt, sof tag as latched.
  - The new sample goes to lane 0, cnt=1, and the frame-sof tag is latched for the new word.
  - With N_PACK=1, the new word is pushed immediately with sof=1.
- Only one push per cycle is possible. A sof flush and a full-word completion never coincide, because a sof sample always starts a new word.
- i_sof with i_nd=0 is ignored.
- Latency: the word-completing sample at edge k gives o_dv=1 after edge k when the FIFO was empty (1 cycle).
- FIFO behaviour:
  - Show-ahead: ov_data, ov_nvld and o_sof reflect the head entry whenever o_dv=1.
  - These outputs are held stable while o_dv=1 and i_rdy=0.
  - They read 0 when the FIFO is empty.
- Handshake:
  - Pop on o_dv & i_rdy.
  - o_dv = FIFO non-empty.
  - i_rdy while o_dv=0 has no effect.
- Full FIFO:
  - A push with no simultaneous pop is dropped and o_ovf is set.
  - Push and pop in the same cycle while full: both happen, no drop, occupancy unchanged.
  - Push and pop while empty: the word is written, o_dv=1 next cycle (no bypass).
- o_ovf clears on i_clr_ovf=1 unless a drop occurs in the same cycle; the drop wins.
- Occupancy counter is clog2(DEPTH)+1 bits. Read and write pointers wrap modulo DEPTH.

Decomposition:
- Shared header: clog2 function, and derived constants CNT_W=clog2(N_PACK+1), PTR_W=clog2(DEPTH).
- One sub-module, xsfifo_sa: synchronous show-ahead FIFO.
  - Ports: clk, rst, wr, din, rd, dout, empty, full.
  - Width = BWID*N_PACK + CNT_W + 1.
- Packer logic (counter, assembly register, sof tag, overflow flag) stays in xpack_stream.

Test Plan:
- Defaults, i_rdy=1, samples 0x11,0x22,0x33,0x44 on consecutive cycles → one word 0x44332211, nvld=4, o_dv high exactly 1 cycle after the 0x44 edge.
- i_sof with 0xA0, then 0xA1,0xA2, then i_sof with 0xB0 → word 0x00A2A1A0, nvld=3, sof=1; then 0xB0 starts the next word, sof=1.
- i_rdy=0, 5 full words input (20 samples) → first 4 words held in order, 5th dropped, o_ovf=1; raising i_rdy drains exactly 4 words with unchanged data.
- FIFO full, pop and push in the same cycle → no drop, o_ovf stays 0, occupancy stays 4; pulse i_clr_ovf after a prior drop → o_ovf=0 next cycle.
- rst=0 for one cycle after 2 samples and 2 buffered words → all outputs 0; next 4 samples give word with nvld=4 and no stale lanes.
- N_PACK=1, DEPTH=2: each i_nd yields one word, nvld=1; i_nd with i_sof=0 after an i_sof sample yields sof=0.

Source files
------------

// File: rtl/xpack_stream_pkg.sv
// Shared helpers for the sample packer and its show-ahead FIFO.
package xpack_stream_pkg;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/xsfifo_sa.sv
// Synchronous show-ahead FIFO: dout presents the head entry whenever
// non-empty and reads zero when empty. A write into a full FIFO is only
// accepted when a read happens on the same edge.
module xsfifo_sa
  import xpack_stream_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   count;
  logic             do_rd;
  logic             do_wr;

  // Effective read/write strobes; full-with-read still accepts the write.
  always_comb begin
    empty = (count == '0);
    full  = (count == (PTR_W + 1)'(DEPTH));
    do_rd = rd && !empty;
    do_wr = wr && (!full || do_rd);
    dout  = empty ? '0 : mem[rptr];
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because dout is masked when empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= din;
  end

endmodule

// File: rtl/xpack_stream.sv
// Packs N_PACK consecutive BWID-bit samples into one wide word and queues
// the words in a show-ahead FIFO. A sof sample flushes any partial word
// first. The sample input cannot be stalled, so a word that finds the FIFO
// full is dropped and the sticky o_ovf flag is raised.
//
// Output handshake: o_dv is high whenever a word is held; ov_data, ov_nvld
// and o_sof describe that word and stay stable until the cycle in which
// o_dv and i_rdy are both high, at which edge the word is consumed. i_rdy
// has no effect while o_dv is low.
module xpack_stream
  import xpack_stream_pkg::*;
#(
  parameter int BWID   = 8,
  parameter int N_PACK = 4,
  parameter int DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BWID-1:0]                 iv_data,
  input  logic                            i_nd,
  input  logic                            i_sof,
  input  logic                            i_rdy,
  input  logic                            i_clr_ovf,
  output logic [BWID*N_PACK-1:0]          ov_data,
  output logic [clog2(N_PACK+1)-1:0]      ov_nvld,
  output logic                            o_sof,
  output logic                            o_dv,
  output logic                            o_ovf
);

  localparam int CNT_W = clog2(N_PACK + 1);
  localparam int DW    = BWID * N_PACK;
  localparam int FW    = DW + CNT_W + 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [DW-1:0]    asm_reg;
  logic [DW-1:0]    asm_n;
  logic [DW-1:0]    lane_data;
  logic             sof_tag;
  logic             tag_n;

  logic             push;
  logic [DW-1:0]    push_data;
  logic [CNT_W-1:0] push_nvld;
  logic             push_sof;
  logic             pop;
  logic             drop;

  logic [FW-1:0]    fifo_din;
  logic [FW-1:0]    fifo_dout;
  logic             fifo_empty;
  logic             fifo_full;

  // Assembly register with the current sample inserted at lane cnt.
  always_comb begin
    lane_data = asm_reg;
    for (int l = 0; l < N_PACK; l++) begin
      if (cnt == CNT_W'(l)) lane_data[l*BWID +: BWID] = iv_data;
    end
  end

  // Packer next-state and push generation; at most one push per cycle.
  always_comb begin
    cnt_n     = cnt;
    asm_n     = asm_reg;
    tag_n     = sof_tag;
    push      = 1'b0;
    push_data = '0;
    push_nvld = '0;
    push_sof  = 1'b0;
    if (i_nd) begin
      if (i_sof) begin
        // Flush the partial word; its unused lanes are already zero.
        if (cnt != '0) begin
          push      = 1'b1;
          push_data = asm_reg;
          push_nvld = cnt;
          push_sof  = sof_tag;
        end
        if (N_PACK == 1) begin
          // cnt is always 0 here, so this never collides with the flush.
          push      = 1'b1;
          push_data = DW'(iv_data);
          push_nvld = CNT_W'(1);
          push_sof  = 1'b1;
          cnt_n     = '0;
          asm_n     = '0;
          tag_n     = 1'b0;
        end else begin
          asm_n = DW'(iv_data);
          cnt_n = CNT_W'(1);
          tag_n = 1'b1;
        end
      end else if (cnt == CNT_W'(N_PACK - 1)) begin
        push      = 1'b1;
        push_data = lane_data;
        push_nvld = CNT_W'(N_PACK);
        push_sof  = sof_tag;
        cnt_n     = '0;
        asm_n     = '0;
        tag_n     = 1'b0;
      end else begin
        asm_n = lane_data;
        cnt_n = cnt + 1'b1;
      end
    end
  end

  // Handshake and overflow detection.
  always_comb begin
    o_dv     = !fifo_empty;
    pop      = o_dv && i_rdy;
    drop     = push && fifo_full && !pop;
    fifo_din = {push_sof, push_nvld, push_data};
    ov_data  = fifo_dout[DW-1:0];
    ov_nvld  = fifo_dout[DW +: CNT_W];
    o_sof    = fifo_dout[FW-1];
  end

  // Packer state and sticky overflow; a drop wins over a clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      asm_reg <= '0;
      sof_tag <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      asm_reg <= asm_n;
      sof_tag <= tag_n;
      if (drop)           o_ovf <= 1'b1;
      else if (i_clr_ovf) o_ovf <= 1'b0;
    end
  end

  xsfifo_sa #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (push),
    .din   (fifo_din),
    .rd    (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule
